// File: rtl/uart_pkg.sv
// Shared defaults and state encoding for the UART transmit arbiter.
package uart_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int TIMEOUT_DEF = 1048576;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Saturating watchdog counter; expired flags the cycle the count sits at TIMEOUT-1.
module arb_timeout_cnt
   import uart_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            CW    = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != '1)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a byte-wide UART transmitter.
// Optional packet lock enabled by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0_valid,
   input  logic [NB_DATA-1:0] req0_data,
   input  logic               req0_last,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [NB_DATA-1:0] req1_data,
   input  logic               req1_last,
   output logic               req1_ready,
   output logic               tx_start,
   output logic [NB_DATA-1:0] tx_data,
   input  logic               tx_done_tick,
   output logic [1:0]         grant,
   output logic               busy,
   output logic               err_timeout
);

   arb_state_e         state_q, state_d;
   logic [NB_DATA-1:0] hold_q, hold_d;
   logic [1:0]         grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               tx_start_q, tx_start_d;
   logic               err_q, err_d;
   logic               last_q, last_d;   // index of the requester served last
   logic               run_q;            // keeps ready low while reset is held

   logic [1:0]              vld, elig, rdy;
   logic [1:0][NB_DATA-1:0] dat;
   logic                    sel_idx, accept, locked, wd_expired;

   assign vld = {req1_valid, req0_valid};
   assign dat = {req1_data, req0_data};

`ifdef UART_TX_ARB_LOCK_EN
   logic       lock_q, lock_d;
   logic [1:0] lst;
   assign lst    = {req1_last, req0_last};
   assign locked = lock_q;
`else
   logic unused_last;
   assign unused_last = req0_last ^ req1_last;
   assign locked      = 1'b0;
`endif

   // While locked only the grant holder is eligible.
   assign elig    = locked ? (vld & grant_q) : vld;
   assign sel_idx = elig[1] & (~elig[0] | ~last_q);
   assign accept  = run_q && (state_q == ST_IDLE) && (|elig);
   assign rdy     = accept ? {sel_idx, ~sel_idx} : 2'b00;

   assign req0_ready  = rdy[0];
   assign req1_ready  = rdy[1];
   assign tx_start    = tx_start_q;
   assign tx_data     = hold_q;
   assign grant       = grant_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;

   arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wd (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q != ST_WAIT),
      .enable  (state_q == ST_WAIT),
      .expired (wd_expired)
   );

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      last_d     = last_q;
      tx_start_d = 1'b0;
      err_d      = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_d     = lock_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               hold_d     = dat[sel_idx];
               grant_d    = {sel_idx, ~sel_idx};
               busy_d     = 1'b1;
               tx_start_d = 1'b1;
               state_d    = ST_SEND;
`ifdef UART_TX_ARB_LOCK_EN
               lock_d     = ~lst[sel_idx];
`endif
            end
         end
         ST_SEND: state_d = ST_WAIT;
         ST_WAIT: begin
            // Done wins over a coincident watchdog expiry.
            if (tx_done_tick) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               last_d  = grant_q[1];
               if (!locked) grant_d = 2'b00;
            end else if (wd_expired) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
               grant_d = 2'b00;
`ifdef UART_TX_ARB_LOCK_EN
               lock_d  = 1'b0;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         grant_q    <= 2'b00;
         busy_q     <= 1'b0;
         tx_start_q <= 1'b0;
         err_q      <= 1'b0;
         last_q     <= 1'b1;
         run_q      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         tx_start_q <= tx_start_d;
         err_q      <= err_d;
         last_q     <= last_d;
         run_q      <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
         lock_q     <= lock_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a transaction-level model.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0] req0_data = '0, req1_data = '0;
   logic       req0_last = 1'b1, req1_last = 1'b1;
   logic       req0_ready, req1_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done_tick = 1'b0;
   logic [1:0] grant;
   logic       busy;
   logic       err_timeout;

   int passed = 0;
   int total  = 0;

   // Model: who was served last, who owns the bus, whether a packet lock holds.
   int last_m  = 1;
   int owner_m = 0;
   bit lock_m  = 1'b0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NB_DATA(8), .TIMEOUT(16)) dut (
      .clk          (clk),
      .reset        (reset),
      .req0_valid   (req0_valid),
      .req0_data    (req0_data),
      .req0_last    (req0_last),
      .req0_ready   (req0_ready),
      .req1_valid   (req1_valid),
      .req1_data    (req1_data),
      .req1_last    (req1_last),
      .req1_ready   (req1_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done_tick (tx_done_tick),
      .grant        (grant),
      .busy         (busy),
      .err_timeout  (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int mpick(input bit v0, input bit v1);
      if (lock_m) return owner_m;
      if (v0 && v1) return (last_m == 0) ? 1 : 0;
      return v1 ? 1 : 0;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, {req1_ready, req0_ready}, 0);
      chk({tag, "_start"}, tx_start, 0);
      chk({tag, "_data"}, tx_data, 0);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err_timeout, 0);
   endtask

   // Called just after a rising edge with the DUT idle; returns in the SEND cycle.
   task automatic accept_chk(input bit v0, input bit v1, input logic [7:0] d0, input logic [7:0] d1,
                             input bit l0, input bit l1, output int pick, output logic [7:0] sent);
      req0_valid = v0; req1_valid = v1;
      req0_data  = d0; req1_data  = d1;
      req0_last  = l0; req1_last  = l1;
      pick = mpick(v0, v1);
      #1;
      chk("ready0", req0_ready, pick == 0);
      chk("ready1", req1_ready, pick == 1);
      @(posedge clk); #1;
      sent = tx_data;
      chk("tx_start", tx_start, 1);
      chk("tx_data", tx_data, pick ? d1 : d0);
      chk("grant", grant, pick ? 2 : 1);
      chk("busy_send", busy, 1);
      chk("ready_send", {req1_ready, req0_ready}, 0);
      owner_m = pick;
      if (LOCK_EN) lock_m = !(pick ? l1 : l0);
   endtask

   task automatic finish_chk(input int delay, input bit early);
      tx_done_tick = early;        // a done during SEND must be ignored
      @(posedge clk); #1;
      tx_done_tick = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_start", tx_start, 0);
      repeat (delay) begin
         @(posedge clk); #1;
         chk("wait_busy", busy, 1);
      end
      tx_done_tick = 1'b1;
      @(posedge clk); #1;
      tx_done_tick = 1'b0;
      chk("done_busy", busy, 0);
      chk("done_grant", grant, lock_m ? (owner_m ? 2 : 1) : 0);
      chk("done_err", err_timeout, 0);
      last_m = owner_m;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   initial begin
      int         pick, n0, nsteps;
      logic [7:0] sent;
      logic [7:0] rr_seq [4];
      logic [7:0] lk_seq [5];
      bit         v0, v1, l0, l1;

      rr_seq[0] = 8'h11; rr_seq[1] = 8'h22; rr_seq[2] = 8'h11; rr_seq[3] = 8'h22;
      if (LOCK_EN) begin
         lk_seq[0] = 8'hC0; lk_seq[1] = 8'hC1; lk_seq[2] = 8'hC2; lk_seq[3] = 8'h33; lk_seq[4] = 8'h00;
         nsteps = 4;
      end else begin
         lk_seq[0] = 8'hC0; lk_seq[1] = 8'h33; lk_seq[2] = 8'hC1; lk_seq[3] = 8'h33; lk_seq[4] = 8'hC2;
         nsteps = 5;
      end

      // Reset with busy-looking inputs: every output must stay low.
      #3 reset = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'hFF; tx_done_tick = 1'b1;
      #9;
      chk_all_zero("rst");
      repeat (2) @(posedge clk);
      #1 chk_all_zero("rst_clk");
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; tx_done_tick = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;

      // Single requester, data A5.
      accept_chk(1, 0, 8'hA5, 8'h00, 1, 1, pick, sent);
      finish_chk(3, 0);

      // Watchdog: no done; error pulse 16 cycles after entering WAIT.
      accept_chk(1, 0, 8'h5A, 8'h00, 0, 1, pick, sent);
      req0_valid = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         chk("to_err_early", err_timeout, 0);
         chk("to_busy", busy, 1);
      end
      @(posedge clk); #1;
      chk("to_err_pulse", err_timeout, 1);
      chk("to_busy_clr", busy, 0);
      chk("to_grant_clr", grant, 0);
      lock_m = 1'b0;
      @(posedge clk); #1;
      chk("to_err_one", err_timeout, 0);

      // Reset asserted in WAIT aborts asynchronously.
      accept_chk(1, 1, 8'h77, 8'h88, 1, 1, pick, sent);
      @(posedge clk); #3;
      reset = 1'b0;
      #1 chk_all_zero("rst_wait");
      repeat (2) begin
         @(posedge clk); #1;
         chk("rst_wait_start", tx_start, 0);
         chk("rst_wait_err", err_timeout, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      last_m = 1; lock_m = 1'b0;
      @(posedge clk); #1;

      // Both valid continuously: strict alternation starting with req0.
      for (int i = 0; i < 4; i++) begin
         accept_chk(1, 1, 8'h11, 8'h22, 1, 1, pick, sent);
         chk("rr_order", sent, rr_seq[i]);
         finish_chk(i, 0);
      end

      // Three-byte packet from req0 with req1 pending.
      n0 = 0;
      for (int s = 0; s < nsteps; s++) begin
         accept_chk(1, 1, 8'hC0 + 8'(n0), 8'h33, n0 == 2, 1, pick, sent);
         chk("pkt_order", sent, lk_seq[s]);
         if (pick == 0) n0++;
         finish_chk(1, 0);
      end

      // Randomized traffic.
      for (int it = 0; it < 40; it++) begin
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         if (lock_m) begin
            if (owner_m == 0) v0 = 1'b1; else v1 = 1'b1;
         end
         l0 = 1'($urandom_range(0, 1));
         l1 = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) begin
            tx_done_tick = 1'b1;
            @(posedge clk); #1;
            tx_done_tick = 1'b0;
            chk("idle_done_busy", busy, 0);
            chk("idle_done_start", tx_start, 0);
         end
         accept_chk(v0, v1, 8'($urandom), 8'($urandom), l0, l1, pick, sent);
         finish_chk(int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NB_DATA, default 8, SHALL set the byte width of all data ports.
REQ-002 Parameter TIMEOUT, default 1048576, SHALL set the number of clk cycles allowed for tx_done_tick while in WAIT.
REQ-003 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester has a byte to send.
REQ-006 req0_data / req1_data  input  NB_DATA  byte offered by the requester.
REQ-007 req0_last / req1_last  input  1  byte is the final byte of its packet.
REQ-008 req0_ready / req1_ready  output  1  byte is accepted this cycle when valid&&ready.
REQ-009 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  NB_DATA  byte presented to the UART transmitter, held stable from tx_start until release.
REQ-011 tx_done_tick  input  1  transmitter finished the current byte.
REQ-012 grant  output  2  one-hot current owner; 2'b00 when IDLE and unlocked.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 err_timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND and WAIT.
REQ-016 IDLE: req_i_ready SHALL be combinationally 1 only for the selected requester.
- Selection is round-robin: the requester not served last wins when both are valid.
- A single valid requester SHALL be selected regardless of the pointer.
REQ-017 On valid&&ready, data SHALL be latched into the hold register, grant set, and the next state SHALL be SEND.
REQ-018 SEND SHALL last exactly one cycle with tx_start=1 and tx_data=hold, then go to WAIT.
- Latency: acceptance in cycle N gives tx_start in cycle N+1.
REQ-019 WAIT SHALL clear and run the watchdog counter.
- tx_done_tick returns to IDLE and updates the round-robin pointer to the served requester.
- A count reaching TIMEOUT-1 without tx_done_tick SHALL pulse err_timeout, release any lock and return to IDLE.
REQ-020 tx_done_tick outside WAIT SHALL be ignored.
REQ-021 tx_done_tick and watchdog expiry in the same cycle SHALL be treated as done, with no error pulse.
REQ-022 ready SHALL never be asserted outside IDLE, and both ready outputs SHALL never be 1 in the same cycle.
REQ-023 The watchdog counter SHALL be $clog2(TIMEOUT) bits wide and SHALL saturate, never wrap.

Reset
REQ-024 While reset=0, state SHALL be IDLE and all outputs SHALL be 0, including tx_data, grant, busy and err_timeout.
- The hold register, counter and lock SHALL be cleared.
- The round-robin pointer SHALL be set so that req0 wins first.
REQ-025 Reset asserted mid-transfer SHALL abort immediately with no tx_start or err_timeout emitted.

Configuration
REQ-026 With macro UART_TX_ARB_LOCK_EN defined, a byte accepted with last=0 SHALL lock grant to that requester.
- The other requester SHALL be ignored until a byte with last=1 completes or a timeout occurs.
- grant SHALL stay set in IDLE while locked.
REQ-027 Without UART_TX_ARB_LOCK_EN, the req_last inputs SHALL be ignored and every byte SHALL be re-arbitrated.

Structure
REQ-028 Shared package uart_pkg SHALL hold the NB_DATA default, the TIMEOUT default and the arbiter state enum typedef.
REQ-029 The watchdog SHALL be the sub-module arb_timeout_cnt, with inputs clear and enable and output expired.

Verification
REQ-030 Bench SHALL cover each directed scenario below:
- Only req0 valid with data 8'hA5: ready in cycle N, tx_start with tx_data=8'hA5 in N+1, busy until tx_done_tick.
- Both requesters valid continuously with req0=8'h11 and req1=8'h22: transmitted order 11,22,11,22.
- With UART_TX_ARB_LOCK_EN, req0 sends 3 bytes last=0,0,1 while req1 is valid: all req0 bytes go before req1; without the macro they interleave.
- No tx_done_tick with TIMEOUT=16: err_timeout pulses 16 cycles after entering WAIT, then the FSM is IDLE and the lock is released.
- reset driven low during WAIT: all outputs 0 asynchronously, and first grant after release goes to req0.
